cpu_mem_arbiter: RTL

Two-requester arbiter sharing one single-ported memory between the custom CPU's instruction-fetch channel and its load/store channel. Sits between `u_cpu` and the memory model in `cpu_test_top`. Serialises requests, steers each read response back to the channel that issued it, and counts grants per channel for CPI analysis.

---
 rtl/cpu_mem_arb_pkg.sv | 18 +
 rtl/cpu_mem_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/cpu_mem_arb_pkg.sv
// rtl/cpu_mem_arb_pkg.sv - shared encodings for the CPU instruction/data memory arbiter
package cpu_mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_RSP_WAIT = 2'd2,
    ST_RSP_HOLD = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } arb_owner_e;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/cpu_mem_arbiter.sv
// rtl/cpu_mem_arbiter.sv - shares one single-ported memory between instruction fetch and load/store
module cpu_mem_arbiter
  import cpu_mem_arb_pkg::*;
#(
  parameter int PRIORITY_DATA = 1,
  parameter int AW            = 32
) (
  input  logic          sys_clk,
  input  logic          sys_reset_n,
  input  logic          inst_req_valid,
  output logic          inst_req_ready,
  input  logic [AW-1:0] inst_addr,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [31:0]   inst_rdata,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [AW-1:0] mem_addr,
  input  logic [3:0]    mem_wstrb,
  input  logic [31:0]   mem_wdata,
  output logic          mem_req_ack,
  output logic          read_data_valid,
  input  logic          read_data_ready,
  output logic [31:0]   read_data,
  output logic          m_req_valid,
  input  logic          m_req_ready,
  output logic          m_req_wen,
  output logic [AW-1:0] m_req_addr,
  output logic [3:0]    m_req_wstrb,
  output logic [31:0]   m_req_wdata,
  input  logic          m_rsp_valid,
  output logic          m_rsp_ready,
  input  logic [31:0]   m_rsp_data,
  output logic [31:0]   cnt_inst,
  output logic [31:0]   cnt_data,
  output logic          err_rsp
);

  arb_state_e  r_state;
  arb_owner_e  r_owner;
  arb_owner_e  r_rr_last;
  logic [31:0] r_rsp_q;
  logic [31:0] r_cnt_inst;
  logic [31:0] r_cnt_data;
  logic        r_err;
  logic        r_inst_valid;
  logic        r_data_valid;
  logic        r_rsp_ready;

  logic w_data_pend;
  logic w_in_req;
  logic w_own_data;
  logic w_own_valid;
  logic w_is_write;
  logic w_hs;
  logic w_own_rsp_ready;

  // Tie-break: fixed data priority, or alternate away from the last winner.
  function automatic arb_owner_e pick(input logic inst_p, input logic data_p,
                                      input arb_owner_e last);
    arb_owner_e w_pick;
    if (inst_p && data_p) begin
      if (PRIORITY_DATA != 0) w_pick = OWN_DATA;
      else                    w_pick = (last == OWN_DATA) ? OWN_INST : OWN_DATA;
    end else if (data_p) begin
      w_pick = OWN_DATA;
    end else begin
      w_pick = OWN_INST;
    end
    return w_pick;
  endfunction

  assign w_data_pend     = mem_read | mem_write;
  assign w_in_req        = (r_state == ST_REQ);
  assign w_own_data      = (r_owner == OWN_DATA);
  assign w_own_valid     = w_own_data ? w_data_pend : inst_req_valid;
  assign w_is_write      = w_own_data & mem_write;
  assign w_hs            = m_req_valid & m_req_ready;
  assign w_own_rsp_ready = w_own_data ? read_data_ready : inst_ready;

  assign m_req_valid    = w_in_req & w_own_valid;
  assign m_req_wen      = w_in_req & w_is_write;
  assign m_req_addr     = w_own_data ? mem_addr : inst_addr;
  assign m_req_wstrb    = w_is_write ? mem_wstrb : 4'h0;
  assign m_req_wdata    = w_own_data ? mem_wdata : 32'h0;
  assign inst_req_ready = w_in_req & ~w_own_data & m_req_ready;
  assign mem_req_ack    = w_in_req & w_own_data & m_req_ready;

  assign m_rsp_ready     = r_rsp_ready;
  assign inst_valid      = r_inst_valid;
  assign read_data_valid = r_data_valid;
  assign inst_rdata      = r_rsp_q;
  assign read_data       = r_rsp_q;
  assign cnt_inst        = r_cnt_inst;
  assign cnt_data        = r_cnt_data;
  assign err_rsp         = r_err;

  always_ff @(posedge sys_clk) begin
    if (!sys_reset_n) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWN_INST;
      r_rr_last    <= OWN_DATA;
      r_rsp_q      <= 32'h0;
      r_cnt_inst   <= 32'h0;
      r_cnt_data   <= 32'h0;
      r_err        <= 1'b0;
      r_inst_valid <= 1'b0;
      r_data_valid <= 1'b0;
      r_rsp_ready  <= 1'b0;
    end else begin
      if (m_rsp_valid && (r_state != ST_RSP_WAIT)) r_err <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (inst_req_valid || w_data_pend) begin
            r_owner <= pick(inst_req_valid, w_data_pend, r_rr_last);
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          // The grant stays with the owner until it handshakes, even if it withdraws.
          if (w_hs) begin
            r_rr_last <= r_owner;
            if (w_own_data) begin
              if (r_cnt_data != CNT_MAX) r_cnt_data <= r_cnt_data + 32'd1;
            end else begin
              if (r_cnt_inst != CNT_MAX) r_cnt_inst <= r_cnt_inst + 32'd1;
            end
            if (w_is_write) begin
              r_state <= ST_IDLE;
            end else begin
              r_state     <= ST_RSP_WAIT;
              r_rsp_ready <= 1'b1;
            end
          end
        end
        ST_RSP_WAIT: begin
          if (m_rsp_valid) begin
            r_rsp_q     <= m_rsp_data;
            r_rsp_ready <= 1'b0;
            r_state     <= ST_RSP_HOLD;
            if (w_own_data) r_data_valid <= 1'b1;
            else            r_inst_valid <= 1'b1;
          end
        end
        ST_RSP_HOLD: begin
          if (w_own_rsp_ready) begin
            r_inst_valid <= 1'b0;
            r_data_valid <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
